// File: rtl/spwm_if.sv
// Control and gate-drive bundle for the SPWM generator.
// Master drives run/increment/mode; slave returns gate drive and status.
interface spwm_if #(
    parameter int CW = 14,
    parameter int SW = 5
);
    logic          en;
    logic [CW-1:0] inc;
    logic          mode;
    logic          pwm_P;
    logic          pwm_N;
    logic          half;
    logic [SW-1:0] step;
    logic          sync;

    modport master (
        output en, inc, mode,
        input  pwm_P, pwm_N, half, step, sync
    );

    modport slave (
        input  en, inc, mode,
        output pwm_P, pwm_N, half, step, sync
    );
endinterface

// File: rtl/spwm_gen.sv
// Sinusoidal PWM generator: triangular step sequence modulates carrier duty.
// Half-wave alternating or bipolar complementary output with dead time.
module spwm_gen #(
    parameter int CW     = 14,
    parameter int PERIOD = 9999,
    parameter int SW     = 5,
    parameter int STEPS  = 21,
    parameter int DEAD   = 8
) (
    input logic   clk,
    input logic   rst,
    spwm_if.slave bus
);
    localparam int DW = $clog2(DEAD + 1) + 1;
    localparam int PW = CW + SW;
    localparam logic [PW-1:0] LIM    = PW'(PERIOD + 1);
    localparam logic [PW-1:0] HALF_P = PW'((PERIOD + 1) / 2);
    localparam logic [0:0] DIR_UP = 1'b0;
    localparam logic [0:0] DIR_DN = 1'b1;

    logic [CW-1:0] cnt;
    logic [SW-1:0] step;
    logic [0:0]    dir;
    logic          half;
    logic          mode_q;
    logic [CW:0]   duty;
    logic          raw_q;
    logic [DW-1:0] dcnt;
    logic          pwm_p;
    logic          pwm_n;

    logic          bnd;
    logic          raw;
    logic [SW-1:0] step_nx;
    logic [0:0]    dir_nx;
    logic          half_nx;
    logic          mode_nx;
    logic [PW-1:0] s;
    logic [PW-1:0] s_m0;
    logic [PW-1:0] s_m1;
    logic [PW-1:0] duty_w;
    logic [CW:0]   duty_nx;
    logic [DW-1:0] dcnt_nx;
    logic          live;

    assign bnd = bus.en && (cnt == CW'(PERIOD));
    assign raw = ({1'b0, cnt} < duty);

    always_comb begin
        step_nx = step;
        dir_nx  = dir;
        half_nx = half;
        if (dir == DIR_UP) begin
            if (step == SW'(STEPS)) begin
                if (STEPS == 1) begin
                    step_nx = '0;
                    half_nx = ~half;
                end else begin
                    step_nx = SW'(STEPS - 1);
                    dir_nx  = DIR_DN;
                end
            end else begin
                step_nx = step + 1'b1;
            end
        end else if (step == SW'(1)) begin
            step_nx = '0;
            dir_nx  = DIR_UP;
            half_nx = ~half;
        end else begin
            step_nx = step - 1'b1;
        end
    end

    // Mode only latches when the next period opens a new positive half
    assign mode_nx = (!half_nx && step_nx == '0) ? bus.mode : mode_q;

    always_comb begin
        s    = PW'(step_nx) * PW'(bus.inc);
        s_m0 = (s > LIM) ? LIM : s;
        s_m1 = (s > HALF_P) ? HALF_P : s;
        if (!mode_nx)
            duty_w = s_m0;
        else if (!half_nx)
            duty_w = HALF_P + s_m1;
        else
            duty_w = HALF_P - s_m1;
        duty_nx = (CW + 1)'(duty_w);
    end

    always_comb begin
        if (raw != raw_q)
            dcnt_nx = '0;
        else if (int'(dcnt) >= DEAD)
            dcnt_nx = dcnt;
        else
            dcnt_nx = dcnt + 1'b1;
        live = (int'(dcnt_nx) >= DEAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            step   <= '0;
            dir    <= DIR_UP;
            half   <= 1'b0;
            mode_q <= 1'b0;
            duty   <= '0;
            raw_q  <= 1'b0;
            dcnt   <= '0;
            pwm_p  <= 1'b0;
            pwm_n  <= 1'b0;
        end else if (bus.en) begin
            cnt <= bnd ? '0 : cnt + 1'b1;
            if (bnd) begin
                step   <= step_nx;
                dir    <= dir_nx;
                half   <= half_nx;
                mode_q <= mode_nx;
                duty   <= duty_nx;
            end
            raw_q <= raw;
            dcnt  <= dcnt_nx;
            if (mode_q) begin
                pwm_p <= raw & live;
                pwm_n <= ~raw & live;
            end else begin
                pwm_p <= raw & ~half;
                pwm_n <= raw & half;
            end
        end else begin
            pwm_p <= 1'b0;
            pwm_n <= 1'b0;
        end
    end

    assign bus.pwm_P = pwm_p;
    assign bus.pwm_N = pwm_n;
    assign bus.half  = half;
    assign bus.step  = step;
    assign bus.sync  = bus.en & (cnt == '0) & (step == '0)
                     & ~half & (dir == DIR_UP);
endmodule

// File: tb/tb_spwm_gen.sv
// Directed bench for spwm_gen at PERIOD=9, STEPS=3, CW=5, SW=3.
// Second instance with zero dead time shares all inputs.
module tb_spwm_gen;
    localparam int CW = 5;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spwm_if #(.CW(CW), .SW(SW)) a_if ();
    spwm_if #(.CW(CW), .SW(SW)) b_if ();

    assign b_if.en   = a_if.en;
    assign b_if.inc  = a_if.inc;
    assign b_if.mode = a_if.mode;

    spwm_gen #(
        .CW(CW), .PERIOD(9), .SW(SW), .STEPS(3), .DEAD(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(a_if)
    );

    spwm_gen #(
        .CW(CW), .PERIOD(9), .SW(SW), .STEPS(3), .DEAD(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(b_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int wp, wn, wpb, cm, sy;
    int ov  = 0;
    int ovb = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wp  = 0;
        wn  = 0;
        wpb = 0;
        cm  = 0;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            wp  += int'(a_if.pwm_P);
            wn  += int'(a_if.pwm_N);
            wpb += int'(b_if.pwm_P);
            cm  += int'(b_if.pwm_N === b_if.pwm_P);
            sy  += int'(a_if.sync);
            ov  += int'(a_if.pwm_P & a_if.pwm_N);
            ovb += int'(b_if.pwm_P & b_if.pwm_N);
        end
    endtask

    task automatic per(input string tag, input int ep, input int exn);
        clr();
        cyc(10);
        chk({tag, "_P"}, wp, ep);
        chk({tag, "_N"}, wn, exn);
    endtask

    int p1p[12] = '{0, 2, 4, 6, 4, 2, 0, 0, 0, 0, 0, 0};
    int p1n[12] = '{0, 0, 0, 0, 0, 0, 0, 2, 4, 6, 4, 2};
    int st[6]   = '{0, 1, 2, 3, 2, 1};
    int p3p[12] = '{3, 5, 7, 8, 9, 5, 3, 1, 0, 0, 0, 1};
    int p3n[12] = '{3, 1, 0, 0, 0, 1, 3, 5, 7, 10, 7, 5};
    int p3b[12] = '{5, 7, 9, 10, 9, 7, 5, 3, 1, 0, 1, 3};

    initial begin
        rst       = 1'b1;
        a_if.en   = 1'b0;
        a_if.inc  = 5'd2;
        a_if.mode = 1'b0;
        sy        = 0;
        clr();
        repeat (2) @(negedge clk);
        chk("rst_P", int'(a_if.pwm_P), 0);
        chk("rst_N", int'(a_if.pwm_N), 0);
        chk("rst_step", int'(a_if.step), 0);
        chk("rst_half", int'(a_if.half), 0);
        chk("rst_sync", int'(a_if.sync), 0);

        rst     = 1'b0;
        a_if.en = 1'b1;
        #1;
        chk("sync_first", int'(a_if.sync), 1);

        // Mode 0, inc=2: one full 120-clock cycle
        sy = 0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("p1_step%0d", i), int'(a_if.step), st[i % 6]);
            chk($sformatf("p1_half%0d", i), int'(a_if.half),
                (i >= 6) ? 1 : 0);
            per($sformatf("p1_%0d", i), p1p[i], p1n[i]);
        end
        chk("sync_cnt", sy, 1);
        chk("sync_wrap", int'(a_if.sync), 1);

        // inc change mid-period, clamp at step 3, deferred mode change
        per("p2_s0", 0, 0);
        clr();
        cyc(4);
        a_if.inc = 5'd4;
        cyc(6);
        chk("p2_s1_P", wp, 2);
        chk("p2_s1_N", wn, 0);
        per("p2_s2", 8, 0);
        per("p2_s3", 10, 0);
        a_if.mode = 1'b1;
        per("p2_d2", 8, 0);
        per("p2_d1", 4, 0);
        per("p2_h1s0", 0, 0);
        per("p2_h1s1", 0, 4);
        per("p2_h1s2", 0, 8);
        per("p2_h1s3", 0, 10);
        per("p2_h1d2", 0, 8);
        a_if.inc = 5'd2;
        per("p2_h1d1", 0, 4);

        // Bipolar mode with dead time; zero-dead instance is complementary
        for (int i = 0; i < 12; i++) begin
            per($sformatf("p3_%0d", i), p3p[i], p3n[i]);
            chk($sformatf("p3_b%0d", i), wpb, p3b[i]);
            chk($sformatf("p3_cm%0d", i), cm, 0);
        end

        // Run-enable freeze at cnt=6 of step 1
        per("p4_s0", 3, 3);
        chk("p4_step1", int'(a_if.step), 1);
        clr();
        cyc(6);
        chk("en_pre_P", wp, 4);
        chk("en_pre_N", wn, 0);
        a_if.en = 1'b0;
        clr();
        sy = 0;
        cyc(5);
        chk("en_off_P", wp, 0);
        chk("en_off_N", wn, 0);
        chk("en_off_sync", sy, 0);
        chk("en_off_step", int'(a_if.step), 1);
        a_if.en = 1'b1;
        clr();
        cyc(4);
        chk("en_res_P", wp, 1);
        chk("en_res_N", wn, 1);
        chk("en_res_step", int'(a_if.step), 2);
        per("p4_s2", 7, 0);
        per("p4_s3", 8, 0);
        per("p4_d2", 9, 0);
        per("p4_d1", 5, 1);
        chk("p4_half", int'(a_if.half), 1);
        per("p4_h1s0", 3, 3);

        // Reset mid-negative-half
        cyc(3);
        chk("pre_rst_P", int'(a_if.pwm_P), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_P", int'(a_if.pwm_P), 0);
        chk("mid_rst_N", int'(a_if.pwm_N), 0);
        chk("mid_rst_half", int'(a_if.half), 0);
        chk("mid_rst_step", int'(a_if.step), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_sync", int'(a_if.sync), 1);
        per("p5_s0", 0, 0);
        per("p5_s1", 2, 0);

        chk("overlap", ov, 0);
        chk("overlap_d0", ovb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
